// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: access size codes,
// FSM state encoding, lane geometry and the access-legality check.
package dm_pkg;

    localparam int LANE_W  = 8;
    localparam int WORD_W  = 32;
    localparam int N_LANES = WORD_W / LANE_W;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WT   = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4
    } state_e;

    // An access is rejected when its size code is illegal or the byte
    // address is not naturally aligned to the access size.
    function automatic logic access_err(input logic [1:0] size, input logic [1:0] addr_lo);
        logic err;
        case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = addr_lo[0];
            SZ_WORD: err = (addr_lo != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational lane steering: extracts and extends load data from a
// memory word, and merges right-justified store data into that word.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]        addr_lo,
    input  logic [1:0]        size,
    input  logic              sign,
    input  logic [WORD_W-1:0] word,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] store_word
);

    logic [LANE_W-1:0] word_lanes [N_LANES];
    logic [15:0]       half_sel;
    logic [LANE_W-1:0] byte_sel;

    // Per-lane view of the memory word and the store merge for each lane.
    for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
        localparam int HALF_IDX = gi / 2;
        localparam int HALF_OFS = gi % 2;
        logic              lane_hit;
        logic [LANE_W-1:0] new_lane;

        assign word_lanes[gi] = word[gi*LANE_W +: LANE_W];

        assign lane_hit = ((size == SZ_BYTE) && (addr_lo == 2'(gi))) ||
                          ((size == SZ_HALF) && (addr_lo[1] == 1'(HALF_IDX))) ||
                          (size == SZ_WORD);

        // Bytes always come from wdata[7:0]; halves from wdata[15:0].
        assign new_lane = (size == SZ_BYTE) ? wdata[LANE_W-1:0] :
                          (size == SZ_HALF) ? wdata[HALF_OFS*LANE_W +: LANE_W] :
                                              wdata[gi*LANE_W +: LANE_W];

        assign store_word[gi*LANE_W +: LANE_W] = lane_hit ? new_lane : word_lanes[gi];
    end

    assign byte_sel = word_lanes[addr_lo];
    assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    // Right-justify the selected lane(s) and extend per the signed flag.
    always_comb begin
        load_data = '0;
        case (size)
            SZ_BYTE: load_data = {{24{sign & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = {{16{sign & half_sel[15]}}, half_sel};
            SZ_WORD: load_data = word;
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: accepts one load/store at a time, performs it on a
// single-port synchronous SRAM (sub-word stores by read-modify-write) and
// returns an aligned, extended load result or an error flag.
module dm_responder
    import dm_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int WAIT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = (WAIT > 1) ? $clog2(WAIT) : 1;

    state_e             state_reg, state_next;
    logic               we_reg, signed_reg, err_reg;
    logic [1:0]         size_reg;
    logic [ADDR_W+1:0]  addr_reg;
    logic [31:0]        wdata_reg, word_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               req_err;
    logic [31:0]        load_data, store_word;
    logic               unused_addr;

    // Address bits above the SRAM range are deliberately ignored.
    assign unused_addr = ^req_addr[31:ADDR_W+2];

    assign req_err = access_err(req_size, req_addr[1:0]);

    // State register; reset aborts any access in flight immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    // Next-state decode for the load / store / RMW / error flows.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_err)                             state_next = S_RESP;
                    else if (req_we && req_size == SZ_WORD) state_next = S_WR;
                    else                                     state_next = S_RD;
                end
            end
            S_RD:   state_next = S_WT;
            S_WT:   if (cnt_reg == '0) state_next = we_reg ? S_WR : S_RESP;
            S_WR:   state_next = S_RESP;
            S_RESP: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Request latch: fields are captured only on acceptance in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_reg     <= 1'b0;
            signed_reg <= 1'b0;
            err_reg    <= 1'b0;
            size_reg   <= 2'b00;
            addr_reg   <= '0;
            wdata_reg  <= '0;
        end else if (state_reg == S_IDLE && req_valid) begin
            we_reg     <= req_we;
            signed_reg <= req_signed;
            err_reg    <= req_err;
            size_reg   <= req_size;
            addr_reg   <= req_addr[ADDR_W+1:0];
            wdata_reg  <= req_wdata;
        end
    end

    // Wait counter: armed during RD, counts the SRAM read latency down in WT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (state_reg == S_RD) begin
            cnt_reg <= CNT_W'(WAIT - 1);
        end else if (state_reg == S_WT && cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
    end

    // Read word capture in the final WT cycle, when mem_rdata is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                        word_reg <= '0;
        else if (state_reg == S_WT && cnt_reg == '0)    word_reg <= mem_rdata;
    end

    dm_lane_align u_align (
        .addr_lo    (addr_reg[1:0]),
        .size       (size_reg),
        .sign       (signed_reg),
        .word       (word_reg),
        .wdata      (wdata_reg),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // Outputs come only from state and latched registers.
    assign req_ready = (state_reg == S_IDLE);
    assign mem_en    = (state_reg == S_RD) || (state_reg == S_WR);
    assign mem_we    = (state_reg == S_WR);
    assign mem_addr  = addr_reg[ADDR_W+1:2];
    assign mem_wdata = store_word;
    assign rsp_valid = (state_reg == S_RESP);
    assign rsp_err   = (state_reg == S_RESP) && err_reg;
    assign rsp_rdata = (state_reg == S_RESP && !we_reg && !err_reg) ? load_data : '0;

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder with an SRAM model and a byte-level
// reference memory.
module tb_dm_responder;

    localparam int ADDR_W = 10;
    localparam int WAIT   = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic              req_signed = 1'b0;
    logic [31:0]       req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    always #5 clk = ~clk;

    dm_responder #(.ADDR_W(ADDR_W), .WAIT(WAIT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // SRAM model: read data appears WAIT cycles after the read cycle and is
    // garbage at any other time, so capture timing must be exact.
    logic [31:0] sram [1024];
    logic [31:0] rd_pipe [WAIT];
    always @(posedge clk) begin
        if (mem_en && mem_we) sram[mem_addr] <= mem_wdata;
        rd_pipe[0] <= (mem_en && !mem_we) ? sram[mem_addr] : 32'hBAD0_BAD0;
        for (int i = 1; i < WAIT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[WAIT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] wword;
        int          n_en;
        int          n_we;
        logic [9:0]  maddr;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  ref_mem [4096];
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: byte-addressed memory, little-endian, natural alignment.
    task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input bit commit, output exp_t e, output int lat);
        int nb, a, base;
        logic [31:0] val;
        logic [7:0]  bytes [4];
        e.rdata = '0; e.err = 1'b0; e.wword = '0; e.n_en = 0; e.n_we = 0;
        e.maddr = addr[11:2]; e.cyc = 0;
        e.err = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
                (size == 2'b10 && addr[1:0] != 2'b00);
        lat = 1;
        if (!e.err) begin
            nb   = 1 << size;
            a    = int'(addr[11:0]);
            base = a & ~3;
            if (!we) begin
                val = '0;
                for (int i = 0; i < nb; i++) val[8*i +: 8] = ref_mem[a+i];
                if (sgn && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8*nb));
                e.rdata = val;
                e.n_en  = 1;
                lat     = WAIT + 2;
            end else begin
                for (int j = 0; j < 4; j++) bytes[j] = ref_mem[base+j];
                for (int i = 0; i < nb; i++) bytes[a-base+i] = wdata[8*i +: 8];
                for (int j = 0; j < 4; j++) begin
                    e.wword[8*j +: 8] = bytes[j];
                    if (commit) ref_mem[base+j] = bytes[j];
                end
                e.n_we = 1;
                e.n_en = (nb == 4) ? 1 : 2;
                lat    = (nb == 4) ? 2 : WAIT + 3;
            end
        end
    endtask

    // Present a request (req_valid stays high afterwards) and push the
    // expected response on acceptance when push is set.
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit push);
        exp_t e;
        int   lat, waited;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        waited = 0;
        while (!req_ready) begin
            @(negedge clk);
            waited++;
            if (waited > 100) begin
                $display("FAIL ready_timeout: req_ready stuck at %b, required 1", req_ready);
                $fatal(1, "responder never became ready");
            end
        end
        model(we, size, sgn, addr, wdata, push, e, lat);
        e.cyc = cyc + lat;
        @(posedge clk);
        if (push) exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_rsp_err"},   32'(rsp_err), 32'd0);
        chk({tag, "_mem_en"},    32'(mem_en), 32'd0);
        chk({tag, "_mem_we"},    32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"},  32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    // Monitor: counts memory strobes per transaction and checks each response.
    int          en_cnt = 0, we_cnt = 0;
    logic [31:0] seen_wdata = '0;
    bit          addr_bad = 0, prev_rsp = 0;
    exp_t        me;
    always @(negedge clk) begin
        if (rst) begin
            en_cnt = 0; we_cnt = 0; addr_bad = 0; prev_rsp = 0;
        end else begin
            if (mem_en) begin
                en_cnt++;
                if (exp_q.size() > 0 && mem_addr !== exp_q[0].maddr) addr_bad = 1;
                if (req_ready) chk("ready_in_mem_state", 32'(req_ready), 32'd0);
            end
            if (mem_en && mem_we) begin
                we_cnt++;
                seen_wdata = mem_wdata;
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    me = exp_q.pop_front();
                    $display("rsp @%0d: rdata=%h err=%b en=%0d we=%0d", cyc, rsp_rdata, rsp_err, en_cnt, we_cnt);
                    chk("rsp_rdata", rsp_rdata, me.rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(me.err));
                    chk("rsp_cycle", 32'(cyc), 32'(me.cyc));
                    chk("mem_en_count", 32'(en_cnt), 32'(me.n_en));
                    chk("mem_we_count", 32'(we_cnt), 32'(me.n_we));
                    chk("mem_addr_ok", 32'(addr_bad), 32'd0);
                    chk("ready_in_resp", 32'(req_ready), 32'd0);
                    if (me.n_we > 0) chk("mem_wdata", seen_wdata, me.wword);
                end
                en_cnt = 0; we_cnt = 0; addr_bad = 0;
            end else if (prev_rsp) begin
                chk("rdata_cleared", rsp_rdata, 32'd0);
                chk("err_cleared", 32'(rsp_err), 32'd0);
            end
            prev_rsp = rsp_valid;
        end
    end

    initial begin : stim
        int   r, drain;
        logic [1:0]  sz;
        logic [31:0] ad;

        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Word store then load.
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 1'b1);
        idle(1);

        // Byte/half loads with sign handling.
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h8001_7FF0, 1'b1);
        issue(1'b0, 2'b00, 1'b1, 32'h0000_0022, 32'h0, 1'b1);
        issue(1'b0, 2'b00, 1'b1, 32'h0000_0023, 32'h0, 1'b1);
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0023, 32'h0, 1'b1);
        issue(1'b0, 2'b01, 1'b1, 32'h0000_0020, 32'h0, 1'b1);
        idle(1);

        // Sub-word store via read-modify-write.
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'h1122_3344, 1'b1);
        issue(1'b1, 2'b00, 1'b0, 32'h0000_0041, 32'h0000_00AA, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 1'b1);
        idle(1);

        // Misaligned and illegal accesses.
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0042, 32'h0, 1'b1);
        issue(1'b1, 2'b01, 1'b0, 32'h0000_0043, 32'h0000_5555, 1'b1);
        issue(1'b0, 2'b11, 1'b0, 32'h0000_0040, 32'h0, 1'b1);
        idle(2);

        // Reset during the WT phase of a byte store: nothing may be written.
        issue(1'b1, 2'b00, 1'b0, 32'h0000_0042, 32'h0000_0077, 1'b0);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("abort");
        @(negedge clk);
        #2 rst = 1'b0;
        idle(2);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 1'b1);
        idle(1);

        // Back-to-back loads with req_valid held high.
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 1'b1);
        issue(1'b0, 2'b00, 1'b1, 32'h0000_0023, 32'h0, 1'b1);
        issue(1'b0, 2'b01, 1'b0, 32'h0000_0022, 32'h0, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0, 1'b1);
        idle(2);

        // Randomized traffic over a 16-word region (upper address bits noise).
        for (int w = 0; w < 16; w++)
            issue(1'b1, 2'b10, 1'b0, 32'h100 + 32'(4*w), $urandom, 1'b1);
        for (int n = 0; n < 200; n++) begin
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            ad = ($urandom & 32'hFFFF_F000) | (32'h100 + 32'($urandom_range(0, 63)));
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom, 1'b1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        // Drain the scoreboard with a bounded wait.
        idle(1);
        drain = 0;
        while (exp_q.size() != 0 && drain < 200) begin
            @(negedge clk);
            drain++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
